mem_arbiter: RTL and testbench

- Shares one memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core.
- Accepts one request at a time on valid/ready handshakes and issues it to memory.
- Routes the single memory response back to the requester that owns it.
- Round-robin arbitration prevents starvation when fetch and data accesses collide.

---
 rtl/npc_arb_pkg.sv | 20 ++
 rtl/arb_rr2.sv | 34 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, requester ids, error data.
// No logic here; latency and backpressure live in mem_arbiter.
// Imported by arb_rr2 and mem_arbiter.
package npc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a conflict the requester that did not win last time wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
module arb_rr2
  import npc_arb_pkg::*;
(
  input  logic       ifu_vld,
  input  logic       lsu_vld,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = REQ_IFU;
    if (ifu_vld && lsu_vld) begin
      if (last_grant == REQ_IFU) begin
        grant    = 2'b10;
        grant_id = REQ_LSU;
      end else begin
        grant    = 2'b01;
        grant_id = REQ_IFU;
      end
    end else if (ifu_vld) begin
      grant    = 2'b01;
      grant_id = REQ_IFU;
    end else if (lsu_vld) begin
      grant    = 2'b10;
      grant_id = REQ_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time (optional watchdog: ARB_TIMEOUT_EN).
// Latency: resp_valid in the 4th cycle counting the accept cycle, with an immediate mem ready and next-cycle response.
// Backpressure: req_ready only in IDLE; mem_req_valid holds the latched request until mem_req_ready.
module mem_arbiter
  import npc_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy,
  output logic                resp_err
);

  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  arb_state_t state;
  req_id_t    owner;
  logic       owner_vld;
  req_id_t    last_grant;
  mem_req_t   req_q;
  mem_req_t   win_req;
  logic [1:0] grant;
  logic       grant_id;

  arb_rr2 u_rr (
    .ifu_vld    (ifu_req_valid),
    .lsu_vld    (lsu_req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign ifu_req_ready = !rst && (state == IDLE) && grant[0];
  assign lsu_req_ready = !rst && (state == IDLE) && grant[1];

  // Fetches are always reads with no byte enables.
  always_comb begin
    win_req = '0;
    if (grant_id == REQ_LSU) begin
      win_req.addr  = lsu_addr;
      win_req.wen   = lsu_wen;
      win_req.wdata = lsu_wdata;
      win_req.wmask = lsu_wmask;
    end else begin
      win_req.addr  = ifu_addr;
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wen   = req_q.wen;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;
  assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wd_cnt;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= REQ_IFU;
      owner_vld      <= 1'b0;
      last_grant     <= REQ_IFU;
      req_q          <= '0;
      mem_req_valid  <= 1'b0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_resp_data  <= '0;
      lsu_resp_data  <= '0;
`ifdef ARB_TIMEOUT_EN
      resp_err       <= 1'b0;
      wd_cnt         <= '0;
`endif
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      resp_err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            req_q         <= win_req;
            owner         <= req_id_t'(grant_id);
            owner_vld     <= 1'b1;
            last_grant    <= req_id_t'(grant_id);
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
`ifdef ARB_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
          end
        end
        WAIT: begin
          // Response pulse is registered on the way into RESP so it is high exactly while in RESP.
          if (mem_resp_valid && owner_vld) begin
            if (owner == REQ_LSU) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_data  <= mem_resp_data;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_resp_data  <= mem_resp_data;
            end
            state <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (owner == REQ_LSU) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_data  <= DATA_W'(ARB_ERR_DATA);
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_resp_data  <= DATA_W'(ARB_ERR_DATA);
            end
            resp_err <= 1'b1;
            state    <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          owner_vld <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: handshakes, round-robin alternation, stores, stray responses, reset, watchdog.
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        busy, resp_err;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .resp_err(resp_err)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  // From the first ISSUE cycle with mem_req_ready=1: answer in WAIT, return at the RESP negedge.
  task automatic mem_answer(input logic [31:0] rdata);
    cyc();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    cyc();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    vec++;
    if ({busy, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, resp_err} !== 7'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, resp_err});
    end
    vec++;
    if ({mem_addr, mem_wdata, mem_wen, mem_wmask, ifu_resp_data, lsu_resp_data} !== '0) begin
      errs++;
      $display("FAIL reset_data: addr %h wdata %h ifu %h lsu %h, required all 0",
               mem_addr, mem_wdata, ifu_resp_data, lsu_resp_data);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_ifu_only();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    mem_req_ready = 1'b1;
    #1;
    vec++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errs++;
      $display("FAIL ifu_accept: got ready ifu/lsu %b required 10", {ifu_req_ready, lsu_req_ready});
    end
    cyc();
    ifu_req_valid = 1'b0;
    vec++;
    if ({mem_req_valid, busy, mem_wen, mem_wmask} !== 7'b1100000 || mem_addr !== 32'h8000_0000) begin
      errs++;
      $display("FAIL ifu_issue: got vld %b busy %b wen %b mask %b addr %h required 1 1 0 0000 80000000",
               mem_req_valid, busy, mem_wen, mem_wmask, mem_addr);
    end
    mem_answer(32'h0010_0093);
    vec++;
    if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10 || ifu_resp_data !== 32'h0010_0093) begin
      errs++;
      $display("FAIL ifu_resp: got vld ifu/lsu %b data %h required 10 00100093",
               {ifu_resp_valid, lsu_resp_valid}, ifu_resp_data);
    end
    cyc();
    vec++;
    if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000 || ifu_resp_data !== 32'h0010_0093) begin
      errs++;
      $display("FAIL ifu_after: got vld/busy %b data %h required 000 00100093",
               {ifu_resp_valid, lsu_resp_valid, busy}, ifu_resp_data);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] exp_addr [3];
    logic        exp_lsu  [3];
    exp_addr[0] = 32'h0000_0100; exp_lsu[0] = 1'b1;
    exp_addr[1] = 32'h0000_0200; exp_lsu[1] = 1'b0;
    exp_addr[2] = 32'h0000_0100; exp_lsu[2] = 1'b1;
    ifu_addr      = 32'h0000_0200;
    lsu_addr      = 32'h0000_0100;
    lsu_wen       = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++;
      if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu[i], !exp_lsu[i]}) begin
        errs++;
        $display("FAIL rr_grant%0d: got ready lsu/ifu %b required %b", i,
                 {lsu_req_ready, ifu_req_ready}, {exp_lsu[i], !exp_lsu[i]});
      end
      cyc();
      if (i == 2) begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end
      vec++;
      if (mem_addr !== exp_addr[i] || {ifu_req_ready, lsu_req_ready} !== 2'b00) begin
        errs++;
        $display("FAIL rr_issue%0d: got addr %h ready %b required %h 00", i,
                 mem_addr, {ifu_req_ready, lsu_req_ready}, exp_addr[i]);
      end
      mem_answer(32'h1111_0000 + i);
      vec++;
      if ({lsu_resp_valid, ifu_resp_valid} !== {exp_lsu[i], !exp_lsu[i]}) begin
        errs++;
        $display("FAIL rr_resp%0d: got vld lsu/ifu %b required %b", i,
                 {lsu_resp_valid, ifu_resp_valid}, {exp_lsu[i], !exp_lsu[i]});
      end
      cyc();
    end
    vec++;
    if (lsu_resp_data !== 32'h1111_0002 || ifu_resp_data !== 32'h1111_0001) begin
      errs++;
      $display("FAIL rr_data: got lsu %h ifu %h required 11110002 11110001", lsu_resp_data, ifu_resp_data);
    end
  endtask

  task automatic test_store();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_0100;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hCAFE_BABE;
    lsu_wmask     = 4'b0011;
    mem_req_ready = 1'b0;
    #1;
    vec++;
    if (lsu_req_ready !== 1'b1) begin
      errs++;
      $display("FAIL st_accept: got lsu_req_ready %b required 1", lsu_req_ready);
    end
    cyc();
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'h0BAD_0BAD;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0100 || mem_wen !== 1'b1 ||
          mem_wdata !== 32'hCAFE_BABE || mem_wmask !== 4'b0011) begin
        errs++;
        $display("FAIL st_hold%0d: got vld %b addr %h wen %b wdata %h mask %b required 1 80000100 1 cafebabe 0011",
                 i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
      end
      if (i == 2) mem_req_ready = 1'b1;
      cyc();
    end
    vec++;
    if ({mem_req_valid, busy, lsu_resp_valid} !== 3'b010) begin
      errs++;
      $display("FAIL st_wait: got vld/busy/resp %b required 010", {mem_req_valid, busy, lsu_resp_valid});
    end
    cyc();
    vec++;
    if ({busy, lsu_resp_valid} !== 2'b10) begin
      errs++;
      $display("FAIL st_noack: got busy/resp %b required 10", {busy, lsu_resp_valid});
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    cyc();
    mem_resp_valid = 1'b0;
    vec++;
    if ({lsu_resp_valid, ifu_resp_valid, resp_err} !== 3'b100 || lsu_resp_data !== 32'h1234_5678) begin
      errs++;
      $display("FAIL st_ack: got vld lsu/ifu/err %b data %h required 100 12345678",
               {lsu_resp_valid, ifu_resp_valid, resp_err}, lsu_resp_data);
    end
    cyc();
  endtask

  task automatic test_stray();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0055;
    cyc();
    mem_resp_valid = 1'b0;
    vec++;
    if ({busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 4'b0000) begin
      errs++;
      $display("FAIL stray_idle: got busy/req/ifu/lsu %b required 0000",
               {busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    mem_req_ready = 1'b0;
    cyc();
    ifu_req_valid  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0066;
    cyc();
    mem_resp_valid = 1'b0;
    vec++;
    if ({mem_req_valid, busy, ifu_resp_valid, lsu_resp_valid} !== 4'b1100) begin
      errs++;
      $display("FAIL stray_issue: got req/busy/ifu/lsu %b required 1100",
               {mem_req_valid, busy, ifu_resp_valid, lsu_resp_valid});
    end
    mem_req_ready = 1'b1;
    cyc();
    vec++;
    if ({mem_req_valid, busy, ifu_resp_valid} !== 3'b010) begin
      errs++;
      $display("FAIL stray_wait: got req/busy/ifu %b required 010", {mem_req_valid, busy, ifu_resp_valid});
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_A5A5;
    cyc();
    mem_resp_data  = 32'h0000_0077;
    vec++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_A5A5) begin
      errs++;
      $display("FAIL stray_resp: got vld %b data %h required 1 0000a5a5", ifu_resp_valid, ifu_resp_data);
    end
    cyc();
    mem_resp_valid = 1'b0;
    vec++;
    if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000 || ifu_resp_data !== 32'h0000_A5A5) begin
      errs++;
      $display("FAIL stray_resp_state: got busy/ifu/lsu %b data %h required 000 0000a5a5",
               {busy, ifu_resp_valid, lsu_resp_valid}, ifu_resp_data);
    end
  endtask

  task automatic test_reset_wait();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0080;
    mem_req_ready = 1'b1;
    cyc();
    ifu_req_valid = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 4'b0000 ||
        {mem_addr, ifu_resp_data, lsu_resp_data} !== '0) begin
      errs++;
      $display("FAIL rst_wait: got busy/req %b addr %h ifu %h lsu %h required 00 0 0 0",
               {busy, mem_req_valid}, mem_addr, ifu_resp_data, lsu_resp_data);
    end
    cyc();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_BEEF;
    cyc();
    mem_resp_valid = 1'b0;
    vec++;
    if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000 || ifu_resp_data !== 32'h0) begin
      errs++;
      $display("FAIL rst_stray: got busy/ifu/lsu %b data %h required 000 0",
               {busy, ifu_resp_valid, lsu_resp_valid}, ifu_resp_data);
    end
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    #1;
    vec++;
    if (ifu_req_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_reaccept: got ifu_req_ready %b required 1", ifu_req_ready);
    end
    cyc();
    ifu_req_valid = 1'b0;
    mem_answer(32'h0000_0013);
    vec++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_0013 || mem_addr !== 32'h8000_0004) begin
      errs++;
      $display("FAIL rst_serve: got vld %b data %h addr %h required 1 00000013 80000004",
               ifu_resp_valid, ifu_resp_data, mem_addr);
    end
    cyc();
  endtask

  task automatic test_timeout();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_00C0;
    mem_req_ready = 1'b1;
    cyc();
    ifu_req_valid = 1'b0;
    cyc();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      vec++;
      if ({busy, ifu_resp_valid} !== 2'b10) begin
        errs++;
        $display("FAIL to_wait%0d: got busy/resp %b required 10", i, {busy, ifu_resp_valid});
      end
      cyc();
    end
    vec++;
    if ({ifu_resp_valid, resp_err} !== 2'b11 || ifu_resp_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL to_resp: got vld/err %b data %h required 11 deadbeef", {ifu_resp_valid, resp_err}, ifu_resp_data);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_1234;
    cyc();
    mem_resp_valid = 1'b0;
    vec++;
    if ({busy, ifu_resp_valid, resp_err} !== 3'b000) begin
      errs++;
      $display("FAIL to_after: got busy/resp/err %b required 000", {busy, ifu_resp_valid, resp_err});
    end
    cyc();
    vec++;
    if ({busy, ifu_resp_valid} !== 2'b00 || ifu_resp_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL to_late: got busy/resp %b data %h required 00 deadbeef", {busy, ifu_resp_valid}, ifu_resp_data);
    end
`else
    for (int i = 0; i < 40; i++) begin
      vec++;
      if ({busy, ifu_resp_valid, resp_err} !== 3'b100) begin
        errs++;
        $display("FAIL nto_wait%0d: got busy/resp/err %b required 100", i, {busy, ifu_resp_valid, resp_err});
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL nto_recover: got busy %b required 0", busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ifu_only();
    test_conflict();
    test_store();
    test_stray();
    test_reset_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
